exit_arbiter: RTL

EXIT_ARBITER -- requirements
Module: exit_arbiter

---
 rtl/exit_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/exit_arbiter.sv
// Round-robin exit arbiter: drains particle records from N_CELL cells into one exit FIFO stream.
// Latency: grant is combinational in the load cycle; the granted record appears on o_data one cycle later.
// Backpressure: o_valid && !i_ready holds the output register and blocks all grants; i_abort drops it.
//
// Ports:
//   ap_clk, ap_rst_n        clock, asynchronous active-low reset
//   i_start, i_abort        begin a drain phase / abandon the current phase
//   i_req, i_data           per-cell record-present flags and packed records (cell k at k*DATA_WIDTH)
//   i_cell_done             per-cell "no more requests this phase" level
//   o_grant                 one-hot (or zero) pop strobe back to the cells
//   o_valid, o_data,
//   o_cell_id, i_ready      record stream toward the exit FIFO
//   o_busy, o_done, o_count phase status and transferred-record counter
module exit_arbiter #(
    parameter int N_CELL     = 27,
    parameter int DATA_WIDTH = 97,
    parameter int CNT_WIDTH  = 16,
    // A single-cell build still needs a 1-bit id field.
    localparam int ID_WIDTH  = (N_CELL > 1) ? $clog2(N_CELL) : 1
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         i_start,
    input  logic                         i_abort,
    input  logic [N_CELL-1:0]            i_req,
    input  logic [DATA_WIDTH*N_CELL-1:0] i_data,
    input  logic [N_CELL-1:0]            i_cell_done,
    output logic [N_CELL-1:0]            o_grant,
    output logic                         o_valid,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic [ID_WIDTH-1:0]          o_cell_id,
    input  logic                         i_ready,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [CNT_WIDTH-1:0]         o_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state;
    logic [ID_WIDTH-1:0]   ptr;

    logic                  load_en;
    logic                  found_hi;
    logic                  found_lo;
    logic [ID_WIDTH-1:0]   sel_hi;
    logic [ID_WIDTH-1:0]   sel_lo;
    logic [ID_WIDTH-1:0]   sel;
    logic [ID_WIDTH-1:0]   ptr_next;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  drain_fin;

    // The output register may take a new record when it is empty or being emptied this cycle.
    // Abort kills the load so nothing is popped from a cell that will never be forwarded.
    assign load_en = (state == DRAIN) && (!o_valid || i_ready) && !i_abort;

    // Round-robin pick in two passes: the lowest requester at or above ptr wins; if there is
    // none, the lowest requester overall (the wrap-around case) wins.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        sel_hi   = '0;
        sel_lo   = '0;
        for (int k = 0; k < N_CELL; k++) begin
            if (i_req[k] && !found_hi && (k >= int'(ptr))) begin
                found_hi = 1'b1;
                sel_hi   = ID_WIDTH'(k);
            end
            if (i_req[k] && !found_lo) begin
                found_lo = 1'b1;
                sel_lo   = ID_WIDTH'(k);
            end
        end
    end

    assign sel      = found_hi ? sel_hi : sel_lo;
    assign ptr_next = (int'(sel) == N_CELL - 1) ? '0 : sel + 1'b1;

    // Decode the winner into the pop strobe and the record mux.
    always_comb begin
        o_grant  = '0;
        sel_data = '0;
        for (int k = 0; k < N_CELL; k++) begin
            if (ID_WIDTH'(k) == sel) begin
                sel_data = i_data[k*DATA_WIDTH +: DATA_WIDTH];
                if (load_en && found_lo) begin
                    o_grant[k] = 1'b1;
                end
            end
        end
    end

    // Phase ends once every cell has declared itself finished, nothing is still requesting,
    // and the output register is empty or leaving this cycle.
    assign drain_fin = (&i_cell_done) && (i_req == '0) && (!o_valid || i_ready);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_cell_id <= '0;
            o_count   <= '0;
        end else if (i_abort) begin
            // Abandon the phase: the held record is dropped, the counter keeps its value.
            state   <= IDLE;
            o_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state   <= DRAIN;
                        o_count <= '0;
                    end
                end
                DRAIN: begin
                    if (o_valid && i_ready && (o_count != '1)) begin
                        o_count <= o_count + 1'b1;
                    end
                    if (load_en) begin
                        if (found_lo) begin
                            o_valid   <= 1'b1;
                            o_data    <= sel_data;
                            o_cell_id <= sel;
                            ptr       <= ptr_next;
                        end else begin
                            o_valid   <= 1'b0;
                        end
                    end
                    if (drain_fin) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy = (state == DRAIN);
    assign o_done = (state == DONE);

endmodule
